// File: rtl/mul_add_sequencer_pkg.sv
// Shared types and constants for the shift-and-add multiply sequencer.
package mul_add_sequencer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mul_seq_state_e;

  localparam int MUL_WIDTH = 64;
  localparam int MUL_CNT_W = 7;

endpackage

// File: rtl/mul_add_sequencer_datapath.sv
// Accumulator, shifting multiplicand/multiplier and iteration counter for the MUL sequencer.
// MUL_ADD_SEQ_EARLY_TERM_EN: raise term_o once the remaining multiplier bits are all zero.
module mul_seq_datapath
  import mul_add_sequencer_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic             run_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic [WIDTH-1:0] add_sum_i,
  output logic [WIDTH-1:0] add_a_o,
  output logic [WIDTH-1:0] add_b_o,
  output logic             last_o,
  output logic             term_o
);

  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    count_d  = count_q;
    if (load_i) begin
      acc_d    = '0;
      mcand_d  = op_a_i;
      mplier_d = op_b_i;
      count_d  = '0;
    end else if (step_i) begin
      acc_d    = add_sum_i;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      count_d  = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      count_q  <= count_d;
    end
  end

  // The shared adder is only driven while iterating; it idles at 0+0 otherwise.
  assign add_a_o = run_i ? acc_q : '0;
  assign add_b_o = (run_i && mplier_q[0]) ? mcand_q : '0;
  assign last_o  = (count_q == CNT_W'(WIDTH - 1));

`ifdef MUL_ADD_SEQ_EARLY_TERM_EN
  assign term_o = (mplier_q == '0);
`else
  assign term_o = 1'b0;
`endif

endmodule

// File: rtl/mul_add_sequencer.sv
// LEGv8 MUL sequencer: low WIDTH bits of op_a*op_b via one external shared adder.
// Optional MUL_ADD_SEQ_EARLY_TERM_EN finishes as soon as the multiplier is exhausted.
module mul_add_sequencer
  import mul_add_sequencer_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH,
  parameter int CNT_W = MUL_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             abort,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_sum
);

  mul_seq_state_e   state_q, state_d;
  logic             load, step, run, last, term;
  logic [WIDTH-1:0] product_q, product_d;

  mul_seq_datapath #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) u_dp (
    .clk_i    (clk),
    .reset_i  (reset),
    .load_i   (load),
    .step_i   (step),
    .run_i    (run),
    .op_a_i   (op_a),
    .op_b_i   (op_b),
    .add_sum_i(add_sum),
    .add_a_o  (add_a),
    .add_b_o  (add_b),
    .last_o   (last),
    .term_o   (term)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start && !abort) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (term) begin
          state_d = DONE;
        end else begin
          step = 1'b1;
          if (last) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q != IDLE);
    done = (state_q == DONE);
    run  = (state_q == RUN);
  end

  // The final sum lands in acc on the same edge DONE is entered, so capture it from the adder.
  always_comb begin
    product_d = product_q;
    if (state_q == RUN && state_d == DONE) product_d = add_sum;
  end

  always_ff @(posedge clk) begin
    if (reset) product_q <= '0;
    else       product_q <= product_d;
  end

  assign product = product_q;

endmodule

// File: tb/tb_mul_add_sequencer.sv
// Self-checking bench for mul_add_sequencer: vector table, scoreboard queue and corner sequences.
module tb_mul_add_sequencer;
  localparam int W = 64;
`ifdef MUL_ADD_SEQ_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [W-1:0] op_a, op_b, product, add_a, add_b, add_sum;
  logic         busy, done;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] sb_q[$];

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] p;
  } vec_t;
  vec_t tbl[13];

  mul_add_sequencer #(.WIDTH(W), .CNT_W(7)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .abort  (abort),
    .op_a   (op_a),
    .op_b   (op_b),
    .busy   (busy),
    .done   (done),
    .product(product),
    .add_a  (add_a),
    .add_b  (add_b),
    .add_sum(add_sum)
  );

  assign add_sum = add_a + add_b;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%h, want 0x%h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] b);
    int msb = -1;
    int early;
    for (int i = 0; i < W; i++) if (b[i]) msb = i;
    if (msb < 0) early = 1;
    else early = (msb + 2 > W) ? W : msb + 2;
    return EARLY ? early : W;
  endfunction

  task automatic step_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_done(input int bound, output int edges, output bit seen);
    seen  = 1'b0;
    edges = 0;
    for (int k = 1; k <= bound; k++) begin
      step_cycle();
      if (done) begin
        edges = k;
        seen  = 1'b1;
        break;
      end
    end
  endtask

  task automatic sb_compare(input string name);
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s: done with empty scoreboard, got 0x%h", name, product);
    end else begin
      check(name, product, sb_q.pop_front());
    end
  endtask

  task automatic count_dones(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      step_cycle();
      if (done) n++;
    end
  endtask

  // Called at a negedge with the DUT idle.
  task automatic run_mul(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] p);
    int edges;
    bit seen;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    sb_q.push_back(p);
    step_cycle();
    start = 1'b0;
    check("busy_after_start", {63'd0, busy}, 64'd1);
    wait_done(W + 4, edges, seen);
    check("done_seen", {63'd0, seen}, 64'd1);
    if (seen) begin
      check("latency", 64'(edges), 64'(exp_lat(b)));
      check("busy_in_done", {63'd0, busy}, 64'd1);
      sb_compare("product");
      step_cycle();
      check("done_one_cycle", {63'd0, done}, 64'd0);
      check("idle_after_done", {63'd0, busy}, 64'd0);
      check("product_held", product, p);
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  initial begin
    int edges, n, prev_c, period;
    bit seen;
    logic [W-1:0] ra, rb;

    tbl[0]  = '{64'd7, 64'd6, 64'd42};
    tbl[1]  = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1};
    tbl[2]  = '{64'h8000_0000_0000_0000, 64'd2, 64'd0};
    tbl[3]  = '{64'd3, 64'd5, 64'd15};
    tbl[4]  = '{64'h1234_5678_9ABC_DEF0, 64'd0, 64'd0};
    tbl[5]  = '{64'd9, 64'd3, 64'd27};
    tbl[6]  = '{64'd5, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000};
    tbl[7]  = '{64'h1234_5678_9ABC_DEF0, 64'h10, 64'h2345_6789_ABCD_EF00};
    tbl[8]  = '{64'hFFFF_FFFF_FFFF_FFFD, 64'd7, 64'hFFFF_FFFF_FFFF_FFEB};
    for (int i = 9; i < 13; i++) begin
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      tbl[i] = '{ra, rb, ra * rb};
    end

    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    op_a  = '0;
    op_b  = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_product", product, 64'd0);
    check("rst_add_a", add_a, 64'd0);
    check("rst_add_b", add_b, 64'd0);

    for (int i = 0; i < 13; i++) run_mul(tbl[i].a, tbl[i].b, tbl[i].p);

    // Adder drive over the first iterations of 7*6, then let it finish so product=42.
    start = 1'b1;
    op_a  = 64'd7;
    op_b  = 64'd6;
    sb_q.push_back(64'd42);
    step_cycle();
    start = 1'b0;
    check("drv0_add_a", add_a, 64'd0);
    check("drv0_add_b", add_b, 64'd0);
    step_cycle();
    check("drv1_add_a", add_a, 64'd0);
    check("drv1_add_b", add_b, 64'd14);
    step_cycle();
    check("drv2_add_a", add_a, 64'd14);
    check("drv2_add_b", add_b, 64'd28);
    wait_done(W + 4, edges, seen);
    check("drv_done_seen", {63'd0, seen}, 64'd1);
    if (seen) sb_compare("drv_product");
    else void'(sb_q.pop_front());
    step_cycle();
    check("drv_idle", add_a | add_b, 64'd0);

    // Abort at RUN iteration 10.
    start = 1'b1;
    op_a  = 64'd5;
    op_b  = 64'hFFFF_FFFF_FFFF_FFFF;
    step_cycle();
    start = 1'b0;
    repeat (10) step_cycle();
    abort = 1'b1;
    step_cycle();
    abort = 1'b0;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_product", product, 64'd42);
    count_dones(W + 8, n);
    check("abort_no_done", 64'(n), 64'd0);

    // start together with abort in IDLE is dropped.
    start = 1'b1;
    abort = 1'b1;
    step_cycle();
    check("start_abort_dropped", {63'd0, busy}, 64'd0);
    start = 1'b0;
    abort = 1'b0;

    // start held high: back-to-back 3*5, never accepted while busy.
    for (int i = 0; i < 3; i++) sb_q.push_back(64'd15);
    start  = 1'b1;
    op_a   = 64'd3;
    op_b   = 64'd5;
    n      = 0;
    prev_c = -1;
    for (int c = 0; c < 3 * (W + 2) + 10 && n < 3; c++) begin
      step_cycle();
      if (done) begin
        sb_compare("b2b_product");
        if (prev_c >= 0) begin
          period = c - prev_c;
          check("b2b_period", 64'(period), 64'(exp_lat(64'd5) + 2));
        end
        prev_c = c;
        n++;
      end
    end
    start = 1'b0;
    check("b2b_done_count", 64'(n), 64'd3);
    check("b2b_sb_empty", 64'(sb_q.size()), 64'd0);
    sb_q.delete();
    repeat (2) step_cycle();

    // Reset held 3 cycles in the middle of RUN.
    start = 1'b1;
    op_a  = 64'd7;
    op_b  = 64'hFFFF_FFFF_FFFF_FFFF;
    step_cycle();
    start = 1'b0;
    repeat (5) step_cycle();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_done", {63'd0, done}, 64'd0);
    check("midrst_product", product, 64'd0);
    check("midrst_add_a", add_a, 64'd0);
    check("midrst_add_b", add_b, 64'd0);
    count_dones(W + 8, n);
    check("midrst_no_done", 64'(n), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_add_sequencer.md
Name: mul_add_sequencer

Overview:
- Multi-cycle shift-and-add controller that computes the low 64 bits of a 64x64 product (LEGv8 MUL) by sequencing one shared 64-bit ripple adder.
- The adder sits outside this block in the execute stage; this block drives its operands and captures its sum each cycle.
- The pipeline controller stalls on busy, can abort on flush, and takes product on the done pulse.

Parameters:
- WIDTH, 64, operand, accumulator and adder width.
- CNT_W, 7, iteration counter width (holds 0..WIDTH-1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply; sampled only in IDLE.
- abort  input  1  pipeline flush; cancels the operation in flight.
- op_a  input  WIDTH  multiplicand, captured on the accepted start.
- op_b  input  WIDTH  multiplier, captured on the accepted start.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse, product valid.
- product  output  WIDTH  low WIDTH bits of op_a*op_b; held until the next accepted start.
- add_a  output  WIDTH  adder operand A.
- add_b  output  WIDTH  adder operand B.
- add_sum  input  WIDTH  adder result, combinational from add_a/add_b.

Behaviour:
- Reset is synchronous and active-high. Effect: state=IDLE; busy=0, done=0, product=0; acc, mcand, mplier and count cleared; add_a=add_b=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 and abort=0 -> capture acc=0, mcand=op_a, mplier=op_b, count=0; go to RUN.
  - start=1 and abort=1 -> start is dropped; stay in IDLE.
- RUN, every edge:
  - abort=1 -> IDLE; no done; product unchanged.
  - Otherwise: acc<=add_sum; mcand<=mcand<<1 (zero fill); mplier<=mplier>>1 (zero fill); count<=count+1.
  - count==WIDTH-1 on that edge -> DONE.
- Adder drive:
  - RUN: add_a=acc; add_b = mplier[0] ? mcand : 0.
  - All other states: add_a=add_b=0.
  - Adder carry-out and overflow are ignored. Wrap modulo 2^WIDTH is the required result, and it is identical for signed and unsigned operands.
- DONE:
  - product<=acc on entry; done=1 for exactly this one cycle.
  - Next edge -> IDLE unconditionally. abort in DONE is ignored.
  - start in DONE is not accepted. It is sampled again on the first IDLE cycle.
- Latency (baseline): done is visible after exactly WIDTH edges following the start-capturing edge. Throughput is one multiply per WIDTH+2 cycles.
- busy is registered state decode, not a function of start.
- Reset mid-RUN/DONE: returns to IDLE next edge, product cleared, no done.

Optional Feature:
- Macro: MUL_ADD_SEQ_EARLY_TERM_EN.
- Defined: in RUN, if mplier==0 (and abort=0), go to DONE on that edge with acc unchanged and no further iterations.
  - Latency = (index of highest set bit of op_b)+2 edges, capped at WIDTH.
  - op_b=0 gives 1 edge.
- Undefined: fixed WIDTH-edge latency regardless of operands.
- product values are identical either way.

Decomposition:
- Shared package holds:
  - state enum mul_seq_state_e {IDLE, RUN, DONE};
  - constants MUL_WIDTH=64 and MUL_CNT_W=7.
- One natural sub-module: mul_seq_datapath holding the acc/mcand/mplier/count registers, with the FSM kept in the top.
- The adder itself is not instantiated here.

Test Plan:
- reset held 3 cycles mid-RUN -> busy=0, done=0, product=0, add_a=add_b=0 on the first post-reset cycle.
- op_a=7, op_b=6, start pulse -> busy for WIDTH+1 cycles; done pulse after 64 edges; product=42.
- op_a=0xFFFF_FFFF_FFFF_FFFF, op_b=0xFFFF_FFFF_FFFF_FFFF -> product=1 (wrap); op_a=2^63, op_b=2 -> product=0.
- abort asserted at RUN iteration 10 -> IDLE next edge, no done, product keeps prior value 42.
- start held high continuously with op_a=3, op_b=5 -> back-to-back results of 15, one multiply per WIDTH+2 cycles, never accepted while busy.
- With MUL_ADD_SEQ_EARLY_TERM_EN:
  - op_b=3, op_a=9 -> done after 3 edges, product=27;
  - op_b=0 -> done after 1 edge, product=0;
  - op_b=2^63 -> done after 64 edges.
